// File: rtl/phase_ctrl_pkg.sv
// rtl/phase_ctrl_pkg.sv - shared state type and activation timeout for the phase scheduler
package phase_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        WAIT_ACT,
        RUN,
        GAP,
        DONE
    } sched_state_e;

    // Cycles a launched channel has to raise its active flag before it is flagged and skipped.
    localparam int ACT_TIMEOUT = 8;
    localparam int ACT_CNT_W   = $clog2(ACT_TIMEOUT);

endpackage

// File: rtl/phase_sched_pick.sv
// rtl/phase_sched_pick.sv - combinational lowest-index masked channel at or above a pointer
// Ports:
//   mask_i  : channels eligible in the current pass
//   ptr_i   : first channel index that may be picked (NUM_CH means past the end)
//   found_o : a channel was found
//   idx_o   : index of the picked channel (0 when none)
module phase_sched_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH),
    parameter int PTR_W  = $clog2(NUM_CH) + 1
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic              found_o,
    output logic [IDX_W-1:0]  idx_o
);

    // Scan downwards so the last hit written is the lowest eligible index.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (PTR_W'(i) >= ptr_i)) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/phase_ctrl_sched.sv
// rtl/phase_ctrl_sched.sv - sequences phase channels one at a time over repeated passes
// Ports:
//   axi_clk, axi_rstn      : clock, synchronous active-low reset
//   sched_en_i             : enable; low aborts a running schedule
//   sched_start_i          : start pulse (captures mask, rep, gap)
//   sched_abort_i          : abort request
//   sched_ch_mask_i        : channels visited in each pass
//   sched_rep_i            : pass count, 0 = continuous
//   sched_gap_i            : idle cycles between channel runs
//   ch_active_i            : per-channel active flag from the phase FSMs
//   ch_fsm_end_i           : per-channel end pulse from the phase FSMs
//   ch_en_o                : channel enables, one-hot or zero
//   sched_cur_ch_o         : current channel index
//   sched_rep_cnt_o        : completed passes (saturating)
//   sched_busy_o           : scheduler not idle
//   sched_done_o           : one-cycle completion pulse
//   sched_aborted_o        : last run was aborted (sticky)
//   sched_err_o            : per-channel activation timeout (sticky)
module phase_ctrl_sched
    import phase_ctrl_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int GAP_WIDTH = 16
) (
    input  logic                      axi_clk,
    input  logic                      axi_rstn,
    input  logic                      sched_en_i,
    input  logic                      sched_start_i,
    input  logic                      sched_abort_i,
    input  logic [NUM_CH-1:0]         sched_ch_mask_i,
    input  logic [7:0]                sched_rep_i,
    input  logic [GAP_WIDTH-1:0]      sched_gap_i,
    input  logic [NUM_CH-1:0]         ch_active_i,
    input  logic [NUM_CH-1:0]         ch_fsm_end_i,
    output logic [NUM_CH-1:0]         ch_en_o,
    output logic [$clog2(NUM_CH)-1:0] sched_cur_ch_o,
    output logic [7:0]                sched_rep_cnt_o,
    output logic                      sched_busy_o,
    output logic                      sched_done_o,
    output logic                      sched_aborted_o,
    output logic [NUM_CH-1:0]         sched_err_o
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int PTR_W = IDX_W + 1;

    sched_state_e           state_q, state_d;
    logic [NUM_CH-1:0]      mask_q, mask_d;
    logic [7:0]             rep_q, rep_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       cur_q, cur_d;
    logic [7:0]             rep_cnt_q, rep_cnt_d;
    logic [ACT_CNT_W-1:0]   act_cnt_q, act_cnt_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_CH-1:0]      ch_en_q, ch_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic [NUM_CH-1:0]      err_q, err_d;

    logic                   pick_found, wrap_found;
    logic [IDX_W-1:0]       pick_idx, wrap_idx;
    logic                   abort_req;
    logic                   more_passes;
    logic [GAP_WIDTH-1:0]   gap_load;
    logic [PTR_W-1:0]       ptr_next_ch;
    logic [NUM_CH-1:0]      cur_onehot;

    phase_sched_pick #(.NUM_CH(NUM_CH)) u_pick_ptr (
        .mask_i  (mask_q),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Second picker from channel 0 lets SELECT wrap into the next pass in the same cycle.
    phase_sched_pick #(.NUM_CH(NUM_CH)) u_pick_wrap (
        .mask_i  (mask_q),
        .ptr_i   ('0),
        .found_o (wrap_found),
        .idx_o   (wrap_idx)
    );

    assign abort_req   = sched_abort_i || !sched_en_i;
    assign more_passes = (rep_q == 8'd0) || (({1'b0, rep_cnt_q} + 9'd1) < {1'b0, rep_q});
    // GAP lasts max(gap,1) cycles: counter counts down to zero inclusive.
    assign gap_load    = (gap_q == '0) ? '0 : gap_q - GAP_WIDTH'(1);
    assign ptr_next_ch = PTR_W'(cur_q) + PTR_W'(1);
    assign cur_onehot  = NUM_CH'(1) << cur_q;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        rep_cnt_d = rep_cnt_q;
        act_cnt_d = act_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ch_en_d   = ch_en_q;
        aborted_d = aborted_q;
        err_d     = err_q;

        if (state_q != IDLE && state_q != DONE && abort_req) begin
            ch_en_d   = '0;
            aborted_d = 1'b1;
            state_d   = DONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sched_en_i && !sched_abort_i && sched_start_i && (sched_ch_mask_i != '0)) begin
                        mask_d    = sched_ch_mask_i;
                        rep_d     = sched_rep_i;
                        gap_d     = sched_gap_i;
                        rep_cnt_d = 8'd0;
                        aborted_d = 1'b0;
                        err_d     = '0;
                        ptr_d     = '0;
                        state_d   = SELECT;
                    end
                end
                SELECT: begin
                    if (pick_found) begin
                        cur_d   = pick_idx;
                        state_d = LAUNCH;
                    end else begin
                        if (rep_cnt_q != 8'hFF) begin
                            rep_cnt_d = rep_cnt_q + 8'd1;
                        end
                        if (more_passes && wrap_found) begin
                            ptr_d   = '0;
                            cur_d   = wrap_idx;
                            state_d = LAUNCH;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                LAUNCH: begin
                    ch_en_d   = cur_onehot;
                    act_cnt_d = '0;
                    state_d   = WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (ch_active_i[cur_q]) begin
                        state_d = RUN;
                    end else if (act_cnt_q == ACT_CNT_W'(ACT_TIMEOUT - 1)) begin
                        err_d[cur_q] = 1'b1;
                        ch_en_d      = '0;
                        ptr_d        = ptr_next_ch;
                        gap_cnt_d    = gap_load;
                        state_d      = GAP;
                    end else begin
                        act_cnt_d = act_cnt_q + ACT_CNT_W'(1);
                    end
                end
                RUN: begin
                    if (ch_fsm_end_i[cur_q] || !ch_active_i[cur_q]) begin
                        ch_en_d   = '0;
                        ptr_d     = ptr_next_ch;
                        gap_cnt_d = gap_load;
                        state_d   = GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = SELECT;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    ch_en_d = '0;
                    state_d = IDLE;
                end
            endcase
        end

        // Status outputs are registered copies of where the FSM is heading.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rstn) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            ptr_q     <= '0;
            cur_q     <= '0;
            rep_cnt_q <= '0;
            act_cnt_q <= '0;
            gap_cnt_q <= '0;
            ch_en_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            rep_cnt_q <= rep_cnt_d;
            act_cnt_q <= act_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ch_en_q   <= ch_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

    assign ch_en_o         = ch_en_q;
    assign sched_cur_ch_o  = cur_q;
    assign sched_rep_cnt_o = rep_cnt_q;
    assign sched_busy_o    = busy_q;
    assign sched_done_o    = done_q;
    assign sched_aborted_o = aborted_q;
    assign sched_err_o     = err_q;

endmodule

// File: tb/tb_phase_ctrl_sched.sv
// tb/tb_phase_ctrl_sched.sv - scoreboard bench for phase_ctrl_sched with channel responders
module tb_phase_ctrl_sched;

    localparam int NUM_CH    = 4;
    localparam int GAP_WIDTH = 16;

    logic                 axi_clk = 1'b0;
    logic                 axi_rstn;
    logic                 sched_en_i;
    logic                 sched_start_i;
    logic                 sched_abort_i;
    logic [NUM_CH-1:0]    sched_ch_mask_i;
    logic [7:0]           sched_rep_i;
    logic [GAP_WIDTH-1:0] sched_gap_i;
    logic [NUM_CH-1:0]    ch_active_i;
    logic [NUM_CH-1:0]    ch_fsm_end_i;
    logic [NUM_CH-1:0]    ch_en_o;
    logic [1:0]           sched_cur_ch_o;
    logic [7:0]           sched_rep_cnt_o;
    logic                 sched_busy_o;
    logic                 sched_done_o;
    logic                 sched_aborted_o;
    logic [NUM_CH-1:0]    sched_err_o;

    phase_ctrl_sched #(.NUM_CH(NUM_CH), .GAP_WIDTH(GAP_WIDTH)) dut (
        .axi_clk         (axi_clk),
        .axi_rstn        (axi_rstn),
        .sched_en_i      (sched_en_i),
        .sched_start_i   (sched_start_i),
        .sched_abort_i   (sched_abort_i),
        .sched_ch_mask_i (sched_ch_mask_i),
        .sched_rep_i     (sched_rep_i),
        .sched_gap_i     (sched_gap_i),
        .ch_active_i     (ch_active_i),
        .ch_fsm_end_i    (ch_fsm_end_i),
        .ch_en_o         (ch_en_o),
        .sched_cur_ch_o  (sched_cur_ch_o),
        .sched_rep_cnt_o (sched_rep_cnt_o),
        .sched_busy_o    (sched_busy_o),
        .sched_done_o    (sched_done_o),
        .sched_aborted_o (sched_aborted_o),
        .sched_err_o     (sched_err_o)
    );

    always #5 axi_clk = ~axi_clk;

    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    typedef struct {
        int rep_cnt;
        int aborted;
        int err;
    } done_t;

    int    ex_launch[$];
    done_t ex_done[$];

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] dead;
    int         cur_gap;
    bit         long_run;
    int         start_cyc;
    bit         first_pending;
    bit         fall_valid;
    int         rise_cyc, fall_cyc, rise_ch;
    int         launches_seen = 0;
    int         done_seen     = 0;
    logic [3:0] prev_en       = '0;

    int rcnt[4], dly[4], len[4];
    bit use_end[4];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nth_ch(input logic [3:0] m, input int n);
        int k = 0;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                if (k == n) return c;
                k++;
            end
        end
        return -1;
    endfunction

    // Behavioural phase FSMs: each enabled channel goes active after a random delay (unless
    // it is dead), runs a while, then either pulses end or drops active. Idle channels emit
    // occasional stray end pulses that the scheduler must ignore.
    task automatic respond();
        for (int c = 0; c < 4; c++) begin
            ch_fsm_end_i[c] = 1'b0;
            if (!ch_en_o[c]) begin
                ch_active_i[c] = 1'b0;
                rcnt[c]        = 0;
                dly[c]         = $urandom_range(1, 5);
                len[c]         = long_run ? $urandom_range(30, 40) : $urandom_range(1, 25);
                use_end[c]     = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) ch_fsm_end_i[c] = 1'b1;
            end else begin
                rcnt[c]++;
                if (!dead[c] && rcnt[c] == dly[c]) begin
                    ch_active_i[c] = 1'b1;
                end else if (ch_active_i[c] && rcnt[c] == dly[c] + len[c]) begin
                    if (use_end[c]) ch_fsm_end_i[c] = 1'b1;
                    else            ch_active_i[c]  = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge axi_clk);
        respond();
    endtask

    // Monitor: compares every enable rise and every done pulse against the scoreboard queues.
    initial begin
        logic [3:0] rises, falls;
        int         idx, e, gmin;
        done_t      d;
        forever begin
            @(negedge axi_clk);
            if (axi_rstn) begin
                chk("en_onehot", int'($countones(ch_en_o) <= 1), 1);
                rises = ch_en_o & ~prev_en;
                falls = ~ch_en_o & prev_en;
                if (rises != 0) begin
                    idx = 0;
                    for (int c = 3; c >= 0; c--) if (rises[c]) idx = c;
                    if (ex_launch.size() == 0) begin
                        chk("unexpected_launch", idx, -1);
                    end else begin
                        e = ex_launch.pop_front();
                        chk("launch_ch", idx, e);
                    end
                    chk("cur_ch", int'(sched_cur_ch_o), idx);
                    gmin = (cur_gap == 0) ? 1 : cur_gap;
                    if (first_pending) begin
                        chk("start_to_en", cyc - start_cyc, 2);
                        first_pending = 0;
                    end else if (fall_valid) begin
                        chk("gap_low_ok", int'((cyc - fall_cyc) >= gmin), 1);
                    end
                    rise_cyc = cyc;
                    rise_ch  = idx;
                    launches_seen++;
                end
                if (falls != 0) begin
                    if (dead[rise_ch]) chk("timeout_len", cyc - rise_cyc, 8);
                    fall_cyc   = cyc;
                    fall_valid = 1;
                end
                if (sched_done_o) begin
                    if (ex_done.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        d = ex_done.pop_front();
                        chk("done_rep_cnt", int'(sched_rep_cnt_o), d.rep_cnt);
                        chk("done_aborted", int'(sched_aborted_o), d.aborted);
                        chk("done_err", int'(sched_err_o), d.err);
                    end
                    done_seen++;
                end
            end
            prev_en = ch_en_o;
        end
    end

    task automatic issue_start(input logic [3:0] mask, input int rep, input int gap);
        tick();
        sched_ch_mask_i = mask;
        sched_rep_i     = 8'(rep);
        sched_gap_i     = GAP_WIDTH'(gap);
        sched_start_i   = 1'b1;
        start_cyc       = cyc + 1;
        first_pending   = 1;
        fall_valid      = 0;
        tick();
        sched_start_i   = 1'b0;
        // Captured values must be used from here on, so the live inputs become noise.
        sched_ch_mask_i = 4'($urandom);
        sched_rep_i     = 8'($urandom);
        sched_gap_i     = GAP_WIDTH'($urandom);
    endtask

    // abort_kind: 0 abort_i, 1 sched_en_i low, 2 abort_i together with end of current channel
    task automatic run_case(input logic [3:0] mask, input int rep, input int gap,
                            input logic [3:0] dmask, input int abort_k, input int abort_kind);
        int  pc, base_done, base_l, t;
        bit  pulsed;
        pc       = $countones(mask);
        dead     = dmask;
        cur_gap  = gap;
        long_run = (abort_k > 0);
        if (abort_k == 0) begin
            for (int p = 0; p < rep; p++)
                for (int c = 0; c < 4; c++)
                    if (mask[c]) ex_launch.push_back(c);
            ex_done.push_back('{rep, 0, int'(mask & dmask)});
        end else begin
            for (int n = 0; n < abort_k; n++) ex_launch.push_back(nth_ch(mask, n % pc));
            ex_done.push_back('{(abort_k - 1) / pc, 1, 0});
        end
        base_done = done_seen;
        base_l    = launches_seen;
        issue_start(mask, rep, gap);

        if (abort_k > 0) begin
            t = 0;
            while (t < 20000 && !((launches_seen - base_l == abort_k) && ((ch_en_o & ch_active_i) != 0))) begin
                tick();
                t++;
            end
            chk("abort_wait", int'(t < 20000), 1);
            tick();
            case (abort_kind)
                0: sched_abort_i = 1'b1;
                1: sched_en_i    = 1'b0;
                default: begin
                    sched_abort_i = 1'b1;
                    ch_fsm_end_i  = ch_en_o;
                end
            endcase
            tick();
            sched_abort_i = 1'b0;
            sched_en_i    = 1'b1;
            chk("abort_en_drop", int'(ch_en_o), 0);
            chk("abort_flag", int'(sched_aborted_o), 1);
        end

        pulsed = 0;
        t = 0;
        while (t < 30000 && done_seen == base_done) begin
            tick();
            if (!pulsed && (launches_seen - base_l >= 1) && sched_busy_o) begin
                sched_start_i = 1'b1;
                pulsed = 1;
            end else begin
                sched_start_i = 1'b0;
            end
            t++;
        end
        sched_start_i = 1'b0;
        chk("done_count", done_seen - base_done, 1);
        tick();
        chk("done_width", int'(sched_done_o), 0);
        chk("busy_after", int'(sched_busy_o), 0);
        chk("launch_queue_empty", ex_launch.size(), 0);
        ex_launch.delete();
        ex_done.delete();
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ch_en"}, int'(ch_en_o), 0);
        chk({tag, "_cur_ch"}, int'(sched_cur_ch_o), 0);
        chk({tag, "_rep_cnt"}, int'(sched_rep_cnt_o), 0);
        chk({tag, "_busy"}, int'(sched_busy_o), 0);
        chk({tag, "_done"}, int'(sched_done_o), 0);
        chk({tag, "_aborted"}, int'(sched_aborted_o), 0);
        chk({tag, "_err"}, int'(sched_err_o), 0);
    endtask

    task automatic reset_case(input logic [3:0] mask);
        int pc, base_l, t;
        pc       = $countones(mask);
        dead     = '0;
        cur_gap  = 1;
        long_run = 1;
        for (int n = 0; n <= pc; n++) ex_launch.push_back(nth_ch(mask, n % pc));
        base_l = launches_seen;
        issue_start(mask, 0, 1);
        t = 0;
        while (t < 20000 && !((launches_seen - base_l == pc + 1) && ((ch_en_o & ch_active_i) != 0))) begin
            tick();
            t++;
        end
        chk("reset_wait", int'(t < 20000), 1);
        tick();
        axi_rstn = 1'b0;
        tick();
        check_all_zero("midrun_reset");
        tick();
        axi_rstn = 1'b1;
        ex_launch.delete();
        repeat (3) tick();
    endtask

    task automatic zero_mask_case();
        int base_done;
        base_done = done_seen;
        tick();
        sched_ch_mask_i = '0;
        sched_rep_i     = 8'd1;
        sched_start_i   = 1'b1;
        tick();
        sched_start_i   = 1'b0;
        repeat (6) begin
            tick();
            chk("zero_mask_busy", int'(sched_busy_o), 0);
        end
        chk("zero_mask_no_done", done_seen - base_done, 0);
    endtask

    initial begin
        logic [3:0] m, dm;
        int         pc;
        axi_rstn        = 1'b0;
        sched_en_i      = 1'b1;
        sched_start_i   = 1'b0;
        sched_abort_i   = 1'b0;
        sched_ch_mask_i = '0;
        sched_rep_i     = '0;
        sched_gap_i     = '0;
        ch_active_i     = '0;
        ch_fsm_end_i    = '0;
        dead            = '0;
        cur_gap         = 1;
        long_run        = 0;
        repeat (3) tick();
        check_all_zero("reset");
        axi_rstn = 1'b1;
        repeat (2) tick();

        run_case(4'b0101, 2, 3, 4'b0000, 0, 0);
        run_case(4'b0010, 2, 2, 4'b0010, 0, 0);
        run_case(4'b1111, 0, 1, 4'b0000, 3, 0);
        run_case(4'b1111, 0, 2, 4'b0000, 5, 2);
        run_case(4'b1011, 0, 0, 4'b0000, 2, 1);
        zero_mask_case();
        reset_case(4'b0110);
        run_case(4'b1001, 1, 1, 4'b0000, 0, 0);

        for (int i = 0; i < 12; i++) begin
            m  = 4'($urandom_range(1, 15));
            pc = $countones(m);
            if (i % 3 == 2) begin
                run_case(m, 0, $urandom_range(0, 5), 4'b0000,
                         $urandom_range(1, 2 * pc), $urandom_range(0, 2));
            end else begin
                dm = ($urandom_range(0, 2) == 0) ? (4'($urandom) & m) : 4'b0000;
                run_case(m, $urandom_range(1, 3), $urandom_range(0, 5), dm, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/phase_ctrl_sched.md
PHASE_CTRL_SCHED -- requirements
Module: phase_ctrl_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of phase channels sequenced (2..8).
REQ-002 SHALL have parameter GAP_WIDTH, default 16, meaning width of the inter-channel gap counter.
REQ-003 SHALL have port axi_clk, input, 1, meaning the single clock for all logic.
REQ-004 SHALL have port axi_rstn, input, 1, meaning synchronous active-low reset.
REQ-005 SHALL have port sched_en_i, input, 1, meaning scheduler enable; low acts as abort.
REQ-006 SHALL have port sched_start_i, input, 1, meaning single-cycle start request.
REQ-007 SHALL have port sched_abort_i, input, 1, meaning abort request.
REQ-008 SHALL have port sched_ch_mask_i, input, NUM_CH, meaning channels included in each pass.
REQ-009 SHALL have port sched_rep_i, input, 8, meaning number of passes; 0 means continuous.
REQ-010 SHALL have port sched_gap_i, input, GAP_WIDTH, meaning idle cycles between channel runs.
REQ-011 SHALL have port ch_active_i, input, NUM_CH, meaning per-channel phase FSM active flag.
REQ-012 SHALL have port ch_fsm_end_i, input, NUM_CH, meaning per-channel phase FSM end pulse.
REQ-013 SHALL have port ch_en_o, output, NUM_CH, meaning channel enables, one-hot or zero.
REQ-014 SHALL have port sched_cur_ch_o, output, $clog2(NUM_CH), meaning index of the current channel.
REQ-015 SHALL have port sched_rep_cnt_o, output, 8, meaning number of completed passes.
REQ-016 SHALL have port sched_busy_o, output, 1, meaning high whenever state is not IDLE.
REQ-017 SHALL have port sched_done_o, output, 1, meaning one-cycle completion pulse.
REQ-018 SHALL have port sched_aborted_o, output, 1, meaning sticky flag set when the last run was aborted.
REQ-019 SHALL have port sched_err_o, output, NUM_CH, meaning sticky per-channel activation-timeout flags.

Function
REQ-020 SHALL implement states IDLE, SELECT, LAUNCH, WAIT_ACT, RUN, GAP, DONE.
REQ-021 In IDLE, start with sched_en_i=1 and a nonzero mask SHALL capture mask, rep and gap, clear rep_cnt, aborted and err, set pointer to 0, and go to SELECT; start with a zero mask SHALL be ignored.
REQ-022 SELECT SHALL pick the lowest-index masked channel >= pointer and go to LAUNCH.
REQ-023 If SELECT finds no channel, it SHALL count one pass by incrementing rep_cnt, saturating at 255.
REQ-024 On that end of pass, if rep=0 or rep_cnt+1<rep, SELECT SHALL wrap the pointer to 0 and re-select in the same cycle; otherwise it SHALL go to DONE.
REQ-025 On entry to LAUNCH, ch_en_o[ch] SHALL be registered high; the rise occurs exactly 2 clocks after start is sampled.
REQ-026 LAUNCH SHALL go to WAIT_ACT after 1 cycle.
REQ-027 WAIT_ACT SHALL go to RUN when ch_active_i[ch]=1.
REQ-028 If ch_active_i[ch] is not seen within 8 cycles of ch_en_o rising, WAIT_ACT SHALL set sched_err_o[ch], drop ch_en_o, and go to GAP.
REQ-029 RUN SHALL exit on ch_fsm_end_i[ch]=1 or on ch_active_i[ch] falling, whichever occurs first.
REQ-030 On RUN exit, ch_en_o SHALL clear on the next edge, the pointer SHALL become ch+1, and the state SHALL go to GAP.
REQ-031 GAP SHALL hold ch_en_o=0 for max(sched_gap_i,1) cycles, guaranteeing an enable low cycle so the channel sees a fresh rising edge, then go to SELECT.
REQ-032 End pulses from non-current channels SHALL be ignored.
REQ-033 sched_abort_i=1 or sched_en_i=0 in any non-IDLE state SHALL clear ch_en_o next edge, set sched_aborted_o, and go to DONE; abort takes priority over simultaneous end or start.
REQ-034 DONE SHALL pulse sched_done_o for 1 cycle and return to IDLE.
REQ-035 Start while busy SHALL be ignored.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 While axi_rstn=0 at a clock edge, state SHALL become IDLE and every output 0: ch_en_o, sched_cur_ch_o, sched_rep_cnt_o, sched_busy_o, sched_done_o, sched_aborted_o, sched_err_o.
REQ-038 Reset mid-run SHALL drop ch_en_o on that edge without a done pulse.

Structure
REQ-039 The state enum typedef and the ACT_TIMEOUT=8 constant SHALL reside in shared package phase_ctrl_pkg.
REQ-040 Next-channel selection SHALL be a sub-module phase_sched_pick (inputs mask and pointer; outputs found and index), purely combinational.

Verification
REQ-041 Mask 4'b0101, rep 2, gap 3, end 20 cycles after active -> enable order ch0,ch2,ch0,ch2; rep_cnt=2; one done pulse; >=3 low cycles between enables.
REQ-042 Mask 4'b0010, ch1 never asserts active -> err=4'b0010 after 8 cycles; passes continue; done with rep_cnt=rep.
REQ-043 Rep 0, mask 4'b1111, abort during ch2 RUN -> ch_en_o=0 next edge; aborted=1; done pulse; busy=0.
REQ-044 Simultaneous ch_fsm_end_i[cur] and abort -> aborted=1 and no further launch.
REQ-045 Reset asserted during RUN -> all outputs 0 next edge; subsequent start behaves as fresh.
REQ-046 Zero mask start, or start while busy -> no state change, no done pulse.
